// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM read port,
// and hands ID a stall-stable instruction word alongside the {ce, pc} bus.
`ifndef IF_FETCH_UNIT_DEFS
`define IF_FETCH_UNIT_DEFS
`define StallBus 5:0
`define Stop 1'b1
`define NoStop 1'b0
`define BR_WD 33
`define IF_TO_ID_WD 33
`endif

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hbfbf_fffc
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [`StallBus]        stall,
  input  logic [`BR_WD-1:0]       br_bus,
  input  logic [31:0]             inst_sram_rdata,
  output logic                    inst_sram_en,
  output logic [3:0]              inst_sram_wen,
  output logic [31:0]             inst_sram_addr,
  output logic [31:0]             inst_sram_wdata,
  output logic [`IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic [31:0]             id_inst
);

  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic        id_ce_q, id_ce_d;
  logic        hold_v_q, hold_v_d;
  logic [31:0] hold_inst_q, hold_inst_d;

  logic        br_e_s;
  logic [31:0] br_addr_s;
  logic [31:0] next_pc_s;
  logic        unused_stall_s;

  assign br_e_s         = br_bus[32];
  assign br_addr_s      = br_bus[31:0];
  assign unused_stall_s = ^stall[5:3];

  // Next-state for PC, pending redirect, IF/ID validity mirror and hold buffer.
  always_comb begin
    pc_d        = pc_q;
    ce_d        = ce_q;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    id_ce_d     = id_ce_q;
    hold_v_d    = hold_v_q;
    hold_inst_d = hold_inst_q;

    // A live redirect outranks one latched during an earlier stall.
    if (br_e_s) begin
      next_pc_s = br_addr_s;
    end else if (pend_v_q) begin
      next_pc_s = pend_addr_q;
    end else begin
      next_pc_s = pc_q + 32'd4;
    end

    if (stall[0] == `NoStop) begin
      pc_d     = next_pc_s;
      ce_d     = 1'b1;
      pend_v_d = 1'b0;
    end else if (br_e_s) begin
      pend_v_d    = 1'b1;
      pend_addr_d = br_addr_s;
    end else begin
      pend_v_d = pend_v_q;
    end

    if ((stall[1] == `Stop) && (stall[2] == `NoStop)) begin
      id_ce_d = 1'b0;
    end else if (stall[1] == `NoStop) begin
      id_ce_d = ce_q;
    end else begin
      id_ce_d = id_ce_q;
    end

    // SRAM data moves on to pc_q's word while ID is frozen, so keep ID's word.
    if (stall[2] == `NoStop) begin
      hold_v_d = 1'b0;
    end else if (!hold_v_q) begin
      hold_v_d    = 1'b1;
      hold_inst_d = inst_sram_rdata;
    end else begin
      hold_v_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      ce_q        <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_addr_q <= 32'h0000_0000;
      id_ce_q     <= 1'b0;
      hold_v_q    <= 1'b0;
      hold_inst_q <= 32'h0000_0000;
    end else begin
      pc_q        <= pc_d;
      ce_q        <= ce_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      id_ce_q     <= id_ce_d;
      hold_v_q    <= hold_v_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  assign inst_sram_en    = ce_q;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_addr  = pc_q;
  assign inst_sram_wdata = 32'h0000_0000;
  assign if_to_id_bus    = ce_q ? {1'b1, pc_q} : {`IF_TO_ID_WD{1'b0}};
  assign id_inst         = !id_ce_q ? 32'h0000_0000 :
                           (hold_v_q ? hold_inst_q : inst_sram_rdata);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: checks the fetch stream and ID's
// instruction word against a fetch-level reference model and an SRAM image.
`ifndef IF_FETCH_UNIT_DEFS
`define IF_FETCH_UNIT_DEFS
`define StallBus 5:0
`define Stop 1'b1
`define NoStop 1'b0
`define BR_WD 33
`define IF_TO_ID_WD 33
`endif

module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hbfbf_fffc;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [31:0] inst_sram_rdata;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [32:0] if_to_id_bus;
  logic [31:0] id_inst;

  int checks = 0;
  int failures = 0;

  // Reference model state: fetch PC, valid, pending redirect, PC held in ID.
  logic [31:0] m_pc;
  logic        m_ce;
  logic        m_pv;
  logic [31:0] m_pa;
  logic        m_idv;
  logic [31:0] m_idpc;

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_bus(br_bus),
    .inst_sram_rdata(inst_sram_rdata), .inst_sram_en(inst_sram_en),
    .inst_sram_wen(inst_sram_wen), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .if_to_id_bus(if_to_id_bus),
    .id_inst(id_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h3c01, a[31:16] ^ 16'h1234} + 32'h0000_0001;
  endfunction

  // Synchronous SRAM: word appears one clock after its address.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_val("sram_en",   {63'd0, inst_sram_en}, {63'd0, m_ce});
    check_val("sram_addr", {32'd0, inst_sram_addr}, {32'd0, m_pc});
    check_val("if_to_id",  {31'd0, if_to_id_bus}, m_ce ? {31'd0, 1'b1, m_pc} : 64'd0);
    check_val("id_inst",   {32'd0, id_inst}, m_idv ? {32'd0, mem_word(m_idpc)} : 64'd0);
  endtask

  task automatic model_edge(input logic r, input logic [2:0] s, input logic be, input logic [31:0] ba);
    if (r) begin
      m_pc = RST_PC; m_ce = 1'b0; m_pv = 1'b0; m_pa = 32'd0; m_idv = 1'b0; m_idpc = 32'd0;
    end else begin
      if (s[1] && !s[2]) m_idv = 1'b0;
      else if (!s[1]) begin m_idv = m_ce; m_idpc = m_pc; end
      if (!s[0]) begin
        m_pc = be ? ba : (m_pv ? m_pa : m_pc + 32'd4);
        m_ce = 1'b1;
        m_pv = 1'b0;
      end else if (be) begin
        m_pv = 1'b1; m_pa = ba;
      end
    end
  endtask

  // One clock: drive inputs, advance model on the edge, compare on the falling edge.
  task automatic cycle(input logic r, input logic [2:0] s, input logic be, input logic [31:0] ba);
    rst = r;
    stall = {3'b000, s};
    br_bus = {be, ba};
    @(posedge clk);
    model_edge(r, s, be, ba);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [2:0] s_r;
    logic [31:0] a_r;
    inst_sram_rdata = 32'd0;
    rst = 1'b1; stall = 6'd0; br_bus = 33'd0;
    m_pc = 32'd0; m_ce = 1'b0; m_pv = 1'b0; m_pa = 32'd0; m_idv = 1'b0; m_idpc = 32'd0;
    @(negedge clk);

    cycle(1'b1, 3'b000, 1'b0, 32'd0);
    cycle(1'b1, 3'b111, 1'b1, 32'h1234_5678);
    check_val("wen_const",   {60'd0, inst_sram_wen}, 64'd0);
    check_val("wdata_const", {32'd0, inst_sram_wdata}, 64'd0);
    // Straight-line fetch then a redirect with its delay slot.
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'b000, 1'b0, 32'd0);
    check_val("addr_seq", {32'd0, inst_sram_addr}, {32'd0, 32'hbfc0_0008});
    cycle(1'b0, 3'b000, 1'b1, 32'hbfc0_0100);
    check_val("redirect", {32'd0, inst_sram_addr}, {32'd0, 32'hbfc0_0100});
    cycle(1'b0, 3'b000, 1'b0, 32'd0);
    // Redirect latched during a PC stall, then two redirects in one stall.
    cycle(1'b0, 3'b001, 1'b1, 32'hbfc0_0200);
    cycle(1'b0, 3'b001, 1'b0, 32'd0);
    cycle(1'b0, 3'b001, 1'b0, 32'd0);
    cycle(1'b0, 3'b000, 1'b0, 32'd0);
    check_val("pend_redirect", {32'd0, inst_sram_addr}, {32'd0, 32'hbfc0_0200});
    cycle(1'b0, 3'b111, 1'b1, 32'hbfc0_0300);
    cycle(1'b0, 3'b111, 1'b1, 32'hbfc0_0400);
    cycle(1'b0, 3'b111, 1'b0, 32'd0);
    cycle(1'b0, 3'b000, 1'b0, 32'd0);
    check_val("latest_pend", {32'd0, inst_sram_addr}, {32'd0, 32'hbfc0_0400});
    // Live redirect beats a pending one on the release edge.
    cycle(1'b0, 3'b001, 1'b1, 32'hbfc0_0500);
    cycle(1'b0, 3'b000, 1'b1, 32'hbfc0_0600);
    check_val("live_over_pend", {32'd0, inst_sram_addr}, {32'd0, 32'hbfc0_0600});
    // Bubble, then wrap-around of the +4 adder.
    cycle(1'b0, 3'b011, 1'b0, 32'd0);
    check_val("bubble", {32'd0, id_inst}, 64'd0);
    cycle(1'b0, 3'b000, 1'b1, 32'hffff_fffc);
    cycle(1'b0, 3'b000, 1'b0, 32'd0);
    check_val("pc_wrap", {32'd0, inst_sram_addr}, 64'd0);
    // Reset in the middle of a stall with a pending redirect.
    cycle(1'b0, 3'b111, 1'b1, 32'hbfc0_0700);
    cycle(1'b1, 3'b111, 1'b0, 32'd0);
    cycle(1'b0, 3'b000, 1'b0, 32'd0);
    check_val("restart", {32'd0, inst_sram_addr}, {32'd0, 32'hbfc0_0000});

    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    s_r = 3'b111;
        2:       s_r = 3'b011;
        3:       s_r = 3'b001;
        default: s_r = 3'b000;
      endcase
      a_r = ($urandom_range(0, 15) == 0) ? 32'hffff_fffc : {$urandom} & 32'hffff_fffc;
      cycle(($urandom_range(0, 99) == 0), s_r, ($urandom_range(0, 3) == 0), a_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
